icache_direct: RTL and testbench

- Direct-mapped, one-word-per-line instruction cache between the fetch unit (IF) and the memory controller's IF port.
- Hits return an instruction one cycle after the request, with no memory traffic.
- Misses issue a single 32-bit fetch to the memory controller, fill the line and forward the word.
- On a pipeline clear, any fetch already in flight runs to completion, fills the line, and is not forwarded.

---
 rtl/icache_direct_if.sv | 34 +++
 rtl/icache_direct.sv | 147 ++++++++++++++
 tb/tb_icache_direct.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signal bundle for icache_direct.
// slave: cache view; master: IF + memory controller view.
interface icache_direct_if;
  logic        if_to_ic_enable;
  logic [31:0] if_to_ic_pc;
  logic        ic_to_if_done;
  logic [31:0] ic_to_if_inst;
  logic        ic_to_mc_enable;
  logic [31:0] ic_to_mc_pc;
  logic        mc_to_ic_done;
  logic [31:0] mc_to_ic_result;

  modport slave (
    input  if_to_ic_enable,
    input  if_to_ic_pc,
    input  mc_to_ic_done,
    input  mc_to_ic_result,
    output ic_to_if_done,
    output ic_to_if_inst,
    output ic_to_mc_enable,
    output ic_to_mc_pc
  );

  modport master (
    output if_to_ic_enable,
    output if_to_ic_pc,
    output mc_to_ic_done,
    output mc_to_ic_result,
    input  ic_to_if_done,
    input  ic_to_if_inst,
    input  ic_to_mc_enable,
    input  ic_to_mc_pc
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache.
// Define ICACHE_STAT_EN to add stat_hit/stat_miss counters.
module icache_direct #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  icache_direct_if.slave   bus
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]      stat_hit,
  output logic [31:0]      stat_miss
`endif
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];

  logic [31:0] miss_pc, miss_pc_n;
  logic        done_q, done_n;
  logic [31:0] inst_q, inst_n;
  logic        mc_en, mc_en_n;

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             hit, fill;
  logic             hit_ev, miss_ev;

  assign req_idx  = bus.if_to_ic_pc[IDX_W+1:2];
  assign req_tag  = bus.if_to_ic_pc[31:IDX_W+2];
  assign fill_idx = miss_pc[IDX_W+1:2];
  assign fill_tag = miss_pc[31:IDX_W+2];
  assign hit = valid[req_idx] && (tags[req_idx] == req_tag);

  assign bus.ic_to_if_done   = done_q;
  assign bus.ic_to_if_inst   = inst_q;
  assign bus.ic_to_mc_enable = mc_en;
  assign bus.ic_to_mc_pc     = miss_pc;

  always_comb begin
    state_n   = state;
    miss_pc_n = miss_pc;
    mc_en_n   = mc_en;
    done_n    = 1'b0;
    inst_n    = '0;
    fill      = 1'b0;
    hit_ev    = 1'b0;
    miss_ev   = 1'b0;
    if (!rdy) begin
      inst_n = inst_q;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.if_to_ic_enable && !clr) begin
            if (hit) begin
              done_n = 1'b1;
              inst_n = data[req_idx];
              hit_ev = 1'b1;
            end else begin
              miss_pc_n = bus.if_to_ic_pc;
              mc_en_n   = 1'b1;
              state_n   = MISS;
              miss_ev   = 1'b1;
            end
          end
        end
        MISS: begin
          if (bus.mc_to_ic_done) begin
            fill    = 1'b1;
            mc_en_n = 1'b0;
            state_n = IDLE;
            if (!clr) begin
              done_n = 1'b1;
              inst_n = bus.mc_to_ic_result;
            end
          end else if (clr) begin
            // memory controller keeps using the live pc; hold it
            state_n = DRAIN;
          end
        end
        DRAIN: begin
          if (bus.mc_to_ic_done) begin
            fill    = 1'b1;
            mc_en_n = 1'b0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      miss_pc <= '0;
      done_q  <= 1'b0;
      inst_q  <= '0;
      mc_en   <= 1'b0;
      valid   <= '0;
    end else begin
      state   <= state_n;
      miss_pc <= miss_pc_n;
      done_q  <= done_n;
      inst_q  <= inst_n;
      mc_en   <= mc_en_n;
      if (fill) valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= bus.mc_to_ic_result;
    end
  end

`ifdef ICACHE_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else begin
      if (hit_ev)  stat_hit  <= stat_hit + 32'd1;
      if (miss_ev) stat_miss <= stat_miss + 32'd1;
    end
  end
`else
  logic stat_unused;
  assign stat_unused = hit_ev ^ miss_ev;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed plan plus random traffic
// against a transaction-level cache/fetch model.
module tb_icache_direct;

  logic clk = 1'b0;
  logic rst, rdy, clr;
  always #5 clk = ~clk;

  icache_direct_if bus();

`ifdef ICACHE_STAT_EN
  logic [31:0] stat_hit, stat_miss;
`endif

  icache_direct #(.IDX_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .clr (clr),
    .bus (bus)
`ifdef ICACHE_STAT_EN
    ,
    .stat_hit  (stat_hit),
    .stat_miss (stat_miss)
`endif
  );

  int checks = 0;
  int failures = 0;
  bit chk_on = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory controller responder
  int          mc_cnt = 0;
  bit          mc_force = 0;
  logic [31:0] mc_force_val = '0;
  int          mc_lat = 3;
  bit          mc_rand = 0;

  always @(negedge clk) begin
    bus.mc_to_ic_done = 1'b0;
    if (rst) begin
      mc_cnt = 0;
    end else if (rdy) begin
      if (mc_cnt > 0) begin
        mc_cnt--;
        if (mc_cnt == 0) begin
          bus.mc_to_ic_done = 1'b1;
          bus.mc_to_ic_result =
            mc_force ? mc_force_val : $urandom;
        end
      end else if (bus.ic_to_mc_enable) begin
        mc_cnt = mc_rand ? $urandom_range(1, 5) : mc_lat;
      end
    end
  end

  // reference model: lines hold the full fetched pc and word
  logic [31:0] line_pc  [int];
  logic [31:0] line_dat [int];
  bit          busy = 0;
  bit          fwd = 0;
  logic [31:0] fl_pc = '0;
  logic        exp_done = 0;
  logic [31:0] exp_inst = '0;
  logic        exp_en = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_hits = '0;
  logic [31:0] exp_miss = '0;

  function automatic int lidx(logic [31:0] a);
    return int'((a >> 2) & 32'hff);
  endfunction

  always @(posedge clk) begin
    int i;
    if (rst) begin
      line_pc.delete();
      line_dat.delete();
      busy = 0;
      exp_done = 0;
      exp_inst = '0;
      exp_en = 0;
      exp_pc = '0;
      exp_hits = '0;
      exp_miss = '0;
    end else if (!rdy) begin
      exp_done = 0;
    end else begin
      exp_done = 0;
      exp_inst = '0;
      if (busy) begin
        if (bus.mc_to_ic_done) begin
          i = lidx(fl_pc);
          line_pc[i] = fl_pc;
          line_dat[i] = bus.mc_to_ic_result;
          if (fwd && !clr) begin
            exp_done = 1;
            exp_inst = bus.mc_to_ic_result;
          end
          busy = 0;
          exp_en = 0;
        end else if (clr) begin
          fwd = 0;
        end
      end else if (bus.if_to_ic_enable && !clr) begin
        i = lidx(bus.if_to_ic_pc);
        if (line_pc.exists(i) &&
            line_pc[i] == bus.if_to_ic_pc) begin
          exp_done = 1;
          exp_inst = line_dat[i];
          exp_hits = exp_hits + 1;
        end else begin
          busy = 1;
          fwd = 1;
          fl_pc = bus.if_to_ic_pc;
          exp_en = 1;
          exp_pc = bus.if_to_ic_pc;
          exp_miss = exp_miss + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("done", {31'b0, bus.ic_to_if_done}, {31'b0, exp_done});
      if (exp_done) chk("inst", bus.ic_to_if_inst, exp_inst);
      chk("mc_en", {31'b0, bus.ic_to_mc_enable}, {31'b0, exp_en});
      if (exp_en) chk("mc_pc", bus.ic_to_mc_pc, exp_pc);
`ifdef ICACHE_STAT_EN
      chk("stat_hit", stat_hit, exp_hits);
      chk("stat_miss", stat_miss, exp_miss);
`endif
    end
  end

  task automatic request(logic [31:0] pc);
    bus.if_to_ic_enable = 1'b1;
    bus.if_to_ic_pc = pc;
    @(posedge clk); #1;
    bus.if_to_ic_enable = 1'b0;
  endtask

  task automatic wait_done(int max, output bit got,
                           output logic [31:0] inst);
    got = 0;
    inst = '0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      if (bus.ic_to_if_done) begin
        got = 1;
        inst = bus.ic_to_if_inst;
      end
    end
  endtask

  task automatic set_mem(logic [31:0] v, int lat);
    mc_force = 1;
    mc_force_val = v;
    mc_lat = lat;
  endtask

  bit          got;
  logic [31:0] inst;
  bit          saw;

  initial begin
    rst = 1; rdy = 1; clr = 0;
    bus.if_to_ic_enable = 0;
    bus.if_to_ic_pc = '0;
    bus.mc_to_ic_done = 0;
    bus.mc_to_ic_result = '0;
    @(posedge clk); #1;
    chk_on = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_done", {31'b0, bus.ic_to_if_done}, 32'd0);
    chk("rst_en", {31'b0, bus.ic_to_mc_enable}, 32'd0);

    // cold miss
    set_mem(32'h13, 10);
    request(32'h0);
    @(negedge clk);
    chk("cold_en", {31'b0, bus.ic_to_mc_enable}, 32'd1);
    chk("cold_pc", bus.ic_to_mc_pc, 32'h0);
    wait_done(30, got, inst);
    chk("cold_got", {31'b0, got}, 32'd1);
    chk("cold_inst", inst, 32'h13);
    chk("cold_en_drop", {31'b0, bus.ic_to_mc_enable}, 32'd0);

    // hit after fill
    request(32'h0);
    @(negedge clk);
    chk("hit_done", {31'b0, bus.ic_to_if_done}, 32'd1);
    chk("hit_inst", bus.ic_to_if_inst, 32'h13);
    chk("hit_en", {31'b0, bus.ic_to_mc_enable}, 32'd0);

    // back-to-back hits on 0x0 and 0x4
    set_mem(32'h4444_0001, 2);
    request(32'h4);
    wait_done(20, got, inst);
    chk("fill4", inst, 32'h4444_0001);
    bus.if_to_ic_enable = 1'b1;
    bus.if_to_ic_pc = 32'h0;
    @(posedge clk); #1;
    bus.if_to_ic_pc = 32'h4;
    @(negedge clk);
    chk("b2b0", bus.ic_to_if_inst, 32'h13);
    @(posedge clk); #1;
    bus.if_to_ic_enable = 1'b0;
    @(negedge clk);
    chk("b2b1_done", {31'b0, bus.ic_to_if_done}, 32'd1);
    chk("b2b1", bus.ic_to_if_inst, 32'h4444_0001);

    // conflict on index 0
    set_mem(32'h400A, 3);
    request(32'h400);
    @(negedge clk);
    chk("conf_pc", bus.ic_to_mc_pc, 32'h400);
    wait_done(20, got, inst);
    chk("conf_inst", inst, 32'h400A);
    set_mem(32'h13, 3);
    request(32'h0);
    @(negedge clk);
    chk("conf_remiss", {31'b0, bus.ic_to_mc_enable}, 32'd1);
    wait_done(20, got, inst);
    chk("conf_refill", inst, 32'h13);

    // clr during miss
    set_mem(32'hDEADBEEF, 6);
    request(32'h20);
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    saw = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.ic_to_if_done) saw = 1;
    end
    chk("clr_nofwd", {31'b0, saw}, 32'd0);
    chk("clr_en", {31'b0, bus.ic_to_mc_enable}, 32'd0);
    request(32'h20);
    @(negedge clk);
    chk("clr_hit", {31'b0, bus.ic_to_if_done}, 32'd1);
    chk("clr_inst", bus.ic_to_if_inst, 32'hDEADBEEF);

    // freeze mid-miss, then reset
    set_mem(32'h80, 20);
    request(32'h80);
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("frz_en", {31'b0, bus.ic_to_mc_enable}, 32'd1);
    chk("frz_pc", bus.ic_to_mc_pc, 32'h80);
    @(posedge clk); #1;
    rdy = 1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_en", {31'b0, bus.ic_to_mc_enable}, 32'd0);
`ifdef ICACHE_STAT_EN
    chk("rst_stat_h", stat_hit, 32'd0);
    chk("rst_stat_m", stat_miss, 32'd0);
`endif
    set_mem(32'h13, 3);
    request(32'h0);
    @(negedge clk);
    chk("rst_remiss", {31'b0, bus.ic_to_mc_enable}, 32'd1);
    wait_done(20, got, inst);
    chk("rst_refill", inst, 32'h13);

    // random traffic
    mc_force = 0;
    mc_rand = 1;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 499) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 9) == 0);
      bus.if_to_ic_enable = ($urandom_range(0, 9) < 6);
      bus.if_to_ic_pc =
        (32'($urandom_range(0, 3)) << 10) |
        (32'($urandom_range(0, 7)) << 2);
    end
    @(posedge clk); #1;
    rst = 0; rdy = 1; clr = 0;
    bus.if_to_ic_enable = 0;
    repeat (10) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
